// File: rtl/mdu_pkg.sv
// Shared types and sizing for the HI/LO multiply/divide unit.
package mdu_pkg;

    localparam int MDU_WIDTH  = 32;
    localparam int ITER_COUNT = MDU_WIDTH;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIXUP,
        DONE
    } mdu_state_t;

    function automatic logic op_is_signed(input mdu_op_t op);
        return (op == MULT) || (op == DIV);
    endfunction

    function automatic logic op_is_div(input mdu_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial-subtract for divide.
module mdu_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] upper;
    logic [WIDTH:0] trial;

    // Multiply keeps the multiplier in the low half and shifts right; divide keeps
    // the partial remainder in the high half and shifts quotient bits in from the right.
    always_comb begin
        sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
        upper = acc_i[2*WIDTH-1:WIDTH-1];
        trial = upper - {1'b0, opnd_i};
        acc_o = acc_i;
        if (is_div_i) begin
            if (trial[WIDTH]) begin
                acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
            end else begin
                acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end
        end else if (acc_i[0]) begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end else begin
            acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_sequencer.sv
// Multicycle HI/LO unit: sequences MULT/MULTU/DIV/DIVU one bit per cycle and owns HI/LO.
module mult_div_sequencer
    import mdu_pkg::*;
#(
    parameter int WIDTH = ITER_COUNT,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_t         state_q;
    mdu_op_t            op_q;
    logic [WIDTH-1:0]   rs_q;
    logic [WIDTH-1:0]   rt_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_q;
    logic               rem_neg_q;
    logic               divz_q;
    logic               busy_q;
    logic               done_q;
    logic               div_zero_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               is_div;
    logic               is_signed;
    logic               rt_zero;
    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [2*WIDTH-1:0] acc_d;

    // Magnitude of 0x8000_0000 is itself when read as unsigned, so no special case is needed.
    always_comb begin
        is_div    = op_is_div(op_q);
        is_signed = op_is_signed(op_q);
        rt_zero   = (rt_q == '0);
        rs_mag    = (is_signed && rs_q[WIDTH-1]) ? (~rs_q + 1'b1) : rs_q;
        rt_mag    = (is_signed && rt_q[WIDTH-1]) ? (~rt_q + 1'b1) : rt_q;
        prod_fix  = neg_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix   = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem_fix   = rem_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    end

    mdu_iter_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .is_div_i(is_div),
        .acc_i   (acc_q),
        .opnd_i  (opnd_q),
        .acc_o   (acc_d)
    );

    // Divide-by-zero still passes through FIXUP so HI/LO update on the same edge as every other op.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= MULT;
            rs_q       <= '0;
            rt_q       <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            divz_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q    <= mdu_op_t'(op);
                        rs_q    <= rs_val;
                        rt_q    <= rt_val;
                        busy_q  <= 1'b1;
                        state_q <= PREP;
                    end else begin
                        if (mthi) hi_q <= wdata;
                        if (mtlo) lo_q <= wdata;
                    end
                end
                PREP: begin
                    cnt_q     <= '0;
                    neg_q     <= is_signed & (rs_q[WIDTH-1] ^ rt_q[WIDTH-1]);
                    rem_neg_q <= is_signed & rs_q[WIDTH-1];
                    acc_q     <= {{WIDTH{1'b0}}, rs_mag};
                    opnd_q    <= rt_mag;
                    divz_q    <= is_div & rt_zero;
                    state_q   <= (is_div && rt_zero) ? FIXUP : ITER;
                end
                ITER: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= FIXUP;
                end
                FIXUP: begin
                    if (divz_q) begin
                        hi_q <= rs_q;
                        lo_q <= '1;
                    end else if (is_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    done_q     <= 1'b1;
                    div_zero_q <= divz_q;
                    state_q    <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Scoreboard bench for mult_div_sequencer: reference results come from native 64-bit arithmetic.
module tb_mult_div_sequencer;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic        Clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int   compared = 0;
    int   failed   = 0;
    int   cycle    = 0;
    exp_t sbQueue[$];

    mult_div_sequencer dut (
        .Clk     (Clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .div_zero(div_zero),
        .hi      (hi),
        .lo      (lo)
    );

    // Free-running clock and a cycle counter used to measure latency from the start edge
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cycle <= cycle + 1;

    // Single comparison point for every check in the bench
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model using the simulator's own 64-bit multiply/divide
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      sq;
        longint      sr;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        ua   = {32'h0, a};
        ub   = {32'h0, b};
        e.dz = 1'b0;
        e.hi = '0;
        e.lo = '0;
        if (o == OP_MULT) begin
            p    = 64'(sa * sb);
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (o == OP_MULTU) begin
            p    = ua * ub;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == 32'h0) begin
            e.hi = a;
            e.lo = 32'hFFFF_FFFF;
            e.dz = 1'b1;
        end else if (o == OP_DIV) begin
            sq   = sa / sb;
            sr   = sa % sb;
            e.hi = sr[31:0];
            e.lo = sq[31:0];
        end else begin
            p    = ua / ub;
            e.lo = p[31:0];
            p    = ua % ub;
            e.hi = p[31:0];
        end
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation
    always @(negedge Clk) begin
        if (done) begin
            if (sbQueue.size() == 0) begin
                checkOutput("sb_unexpectedDone", 64'(done), 64'(0));
            end else begin
                exp_t e;
                e = sbQueue.pop_front();
                checkOutput("sb_hi", 64'(hi), 64'(e.hi));
                checkOutput("sb_lo", 64'(lo), 64'(e.lo));
                checkOutput("sb_divZero", 64'(div_zero), 64'(e.dz));
            end
        end
    end

    // Issue one operation at a falling edge; e0 is the cycle number of the accepting edge
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output int e0);
        int guard;
        guard = 0;
        while (busy && guard < 100) begin
            @(negedge Clk);
            guard++;
        end
        if (busy) checkOutput("idleTimeout", 64'(busy), 64'(0));
        op     = o;
        rs_val = a;
        rt_val = b;
        start  = 1'b1;
        sbQueue.push_back(model(o, a, b));
        e0 = cycle + 1;
        @(negedge Clk);
        start = 1'b0;
        checkOutput("busyAfterStart", 64'(busy), 64'(1));
    endtask

    // Wait (bounded) for done, check its latency and that it is a single-cycle pulse
    task automatic waitDone(input int e0, input int lat, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge Clk);
            if (done) begin
                seen = 1'b1;
                checkOutput({tag, "_latency"}, 64'(cycle - e0), 64'(lat));
                checkOutput({tag, "_busyAtDone"}, 64'(busy), 64'(1));
            end
        end
        if (!seen) checkOutput({tag, "_doneTimeout"}, 64'(seen), 64'(1));
        @(negedge Clk);
        checkOutput({tag, "_donePulse"}, 64'(done), 64'(0));
        checkOutput({tag, "_busyAfter"}, 64'(busy), 64'(0));
    endtask

    task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        int e0;
        int lat;
        lat = (o[1] && b == 32'h0) ? 2 : 34;
        applyStimulus(o, a, b, e0);
        waitDone(e0, lat, tag);
    endtask

    // Hard stop in case something upstream hangs
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          e0;
        int          doneCount;
        logic [31:0] prevHi;
        logic [31:0] prevLo;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  ro;

        reset  = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        rs_val = '0;
        rt_val = '0;
        mthi   = 1'b0;
        mtlo   = 1'b0;
        wdata  = '0;

        repeat (3) @(negedge Clk);
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_done", 64'(done), 64'(0));
        checkOutput("rst_divZero", 64'(div_zero), 64'(0));
        checkOutput("rst_hi", 64'(hi), 64'(0));
        checkOutput("rst_lo", 64'(lo), 64'(0));
        reset = 1'b0;
        @(negedge Clk);
        checkOutput("idle_busy", 64'(busy), 64'(0));

        runOp(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multuMax");
        checkOutput("multuMax_hiConst", 64'(hi), 64'(32'hFFFF_FFFE));
        checkOutput("multuMax_loConst", 64'(lo), 64'(32'h0000_0001));
        runOp(OP_MULT, 32'hFFFF_FFFD, 32'd7, "multNeg");
        runOp(OP_DIV, 32'hFFFF_FFF9, 32'd2, "divNeg");
        checkOutput("divNeg_loConst", 64'(lo), 64'(32'hFFFF_FFFD));
        checkOutput("divNeg_hiConst", 64'(hi), 64'(32'hFFFF_FFFF));
        runOp(OP_DIVU, 32'd100, 32'd7, "divu");
        runOp(OP_DIVU, 32'd100, 32'd0, "divuZero");
        runOp(OP_DIV, 32'hFFFF_FFFB, 32'd0, "divZero");
        runOp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "divOverflow");
        checkOutput("divOverflow_loConst", 64'(lo), 64'(32'h8000_0000));
        runOp(OP_MULT, 32'h8000_0000, 32'h8000_0000, "multMinMin");
        runOp(OP_DIV, 32'd7, 32'hFFFF_FFFE, "divNegDivisor");
        runOp(OP_DIVU, 32'd5, 32'd10, "divuSmall");
        runOp(OP_MULTU, 32'd0, 32'h1234_5678, "multuZero");

        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 2 == 1) ? 32'($urandom_range(1, 100)) : $urandom;
            runOp(ro, ra, rb, "random");
        end

        // Re-pulsed start and an MTHI while busy must both be ignored
        applyStimulus(OP_MULT, 32'd1234, 32'hFFFF_E9D2, e0);
        repeat (5) @(negedge Clk);
        start  = 1'b1;
        op     = OP_DIVU;
        rs_val = 32'd1;
        rt_val = 32'd0;
        mthi   = 1'b1;
        wdata  = 32'h0000_0BAD;
        @(negedge Clk);
        start = 1'b0;
        mthi  = 1'b0;
        waitDone(e0, 34, "repulse");

        // MT writes in IDLE land on the next edge
        prevLo = lo;
        mthi   = 1'b1;
        wdata  = 32'h0000_1234;
        @(negedge Clk);
        mthi = 1'b0;
        checkOutput("mthi_hi", 64'(hi), 64'(32'h0000_1234));
        checkOutput("mthi_loHeld", 64'(lo), 64'(prevLo));
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'hCAFE_F00D;
        @(negedge Clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        checkOutput("mtBoth_hi", 64'(hi), 64'(32'hCAFE_F00D));
        checkOutput("mtBoth_lo", 64'(lo), 64'(32'hCAFE_F00D));

        // MTLO in the same cycle as start loses to the operation
        prevLo = lo;
        prevHi = hi;
        mtlo   = 1'b1;
        wdata  = 32'hDEAD_BEEF;
        applyStimulus(OP_MULTU, 32'd3, 32'd5, e0);
        mtlo = 1'b0;
        checkOutput("mtloWithStart_lo", 64'(lo), 64'(prevLo));
        checkOutput("mtloWithStart_hi", 64'(hi), 64'(prevHi));
        waitDone(e0, 34, "mtloWithStart");

        // Asynchronous reset in the middle of ITER aborts without a done pulse
        applyStimulus(OP_MULTU, 32'h1111_1111, 32'h2222_2222, e0);
        repeat (10) @(negedge Clk);
        sbQueue.delete();
        #2 reset = 1'b1;
        #1;
        checkOutput("abort_busy", 64'(busy), 64'(0));
        checkOutput("abort_hi", 64'(hi), 64'(0));
        checkOutput("abort_lo", 64'(lo), 64'(0));
        checkOutput("abort_done", 64'(done), 64'(0));
        @(negedge Clk);
        reset     = 1'b0;
        doneCount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (done) doneCount++;
        end
        checkOutput("abort_noDone", 64'(doneCount), 64'(0));

        runOp(OP_MULTU, 32'd6, 32'd7, "afterAbort");
        checkOutput("afterAbort_loConst", 64'(lo), 64'(42));
        checkOutput("afterAbort_hiConst", 64'(hi), 64'(0));

        checkOutput("sb_leftover", 64'(sbQueue.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
